addsub_checker: RTL and testbench

ADDSUB_CHECKER -- requirements
Module: addsub_checker

---
 rtl/addsub_checker_if.sv | 29 ++
 rtl/addsub_checker.sv | 80 ++++++++
 tb/tb_addsub_checker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/addsub_checker_if.sv
// addsub_checker_if: vector stream, control and result signals of the add/sub checker
interface addsub_checker_if;
    logic       start;
    logic       halt_on_err;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       M;
    logic [3:0] Sum;
    logic       C_out;
    logic       ov;
    logic       mismatch;
    logic [7:0] pass_count;
    logic [7:0] err_count;
    logic [14:0] fail_vec;
    logic       fail_valid;
    logic [1:0] state;

    modport master (
        output start, halt_on_err, in_valid, A, B, M, Sum, C_out, ov,
        input  in_ready, mismatch, pass_count, err_count, fail_vec, fail_valid, state
    );

    modport slave (
        input  start, halt_on_err, in_valid, A, B, M, Sum, C_out, ov,
        output in_ready, mismatch, pass_count, err_count, fail_vec, fail_valid, state
    );
endinterface

// File: rtl/addsub_checker.sv
// addsub_checker: checks observed 4-bit add/sub results; ADDSUB_CHK_OV_EN also checks overflow
module addsub_checker (
    input logic clk,
    input logic rst,
    addsub_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;

    state_t      st;
    logic        p_valid;
    logic [14:0] p_vec;
    logic [3:0]  pa, pb, ps;
    logic        pm, pc;
    logic [4:0]  exp_cs;
    logic        acc, bad;
    logic [7:0]  pass_q, err_q;
    logic [14:0] fv_q;
    logic        fvalid_q, mis_q;
`ifdef ADDSUB_CHK_OV_EN
    logic        ov_exp;
`endif

    assign {pa, pb, pm, ps, pc} = p_vec[14:1];
    assign bus.in_ready   = st == RUN;
    assign acc            = bus.in_valid && bus.in_ready;
    assign bus.state      = st;
    assign bus.pass_count = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_vec   = fv_q;
    assign bus.fail_valid = fvalid_q;
    assign bus.mismatch   = mis_q;

    // Expected result of the registered vector and the pass/fail verdict
    always_comb begin
        exp_cs = {1'b0, pa} + {1'b0, pm ? ~pb : pb} + {4'b0, pm};
`ifdef ADDSUB_CHK_OV_EN
        ov_exp = pm ? (pa[3] != pb[3] && exp_cs[3] != pa[3]) : (pa[3] == pb[3] && exp_cs[3] != pa[3]);
        bad    = p_valid && ({pc, ps} != exp_cs || p_vec[0] != ov_exp);
`else
        bad    = p_valid && {pc, ps} != exp_cs;
`endif
    end

    // Capture stage, compare stage, tallies, first-fail capture and run/halt FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            p_valid  <= 1'b0;
            p_vec    <= '0;
            pass_q   <= '0;
            err_q    <= '0;
            fv_q     <= '0;
            fvalid_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            p_valid <= acc;
            p_vec   <= {bus.A, bus.B, bus.M, bus.Sum, bus.C_out, bus.ov};
            if (bus.start) begin
                st       <= RUN;
                pass_q   <= '0;
                err_q    <= '0;
                fv_q     <= '0;
                fvalid_q <= 1'b0;
                mis_q    <= 1'b0;
            end else begin
                mis_q <= bad;
                if (p_valid && !bad && pass_q != 8'hff)
                    pass_q <= pass_q + 8'd1;
                if (bad && err_q != 8'hff)
                    err_q <= err_q + 8'd1;
                if (bad && !fvalid_q) begin
                    fv_q     <= p_vec;
                    fvalid_q <= 1'b1;
                end
                if (bad && bus.halt_on_err && st == RUN)
                    st <= HALT;
            end
        end
    end
endmodule

// File: tb/tb_addsub_checker.sv
// tb_addsub_checker: table vectors plus corner sequences checked against a scoreboard model
module tb_addsub_checker;
`ifdef ADDSUB_CHK_OV_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] a, b;
        logic       m;
        logic [3:0] s;
        logic       c, ov, fail_ov, fail_no;
    } vec_t;

    typedef struct {
        logic [14:0] v;
        logic        f;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_checker_if bus();
    addsub_checker dut (.clk(clk), .rst(rst), .bus(bus));

    vec_t        tbl [9];
    exp_t        q [$];
    int          checks = 0;
    int          errors = 0;
    int          m_pass, m_err;
    logic [1:0]  m_st;
    logic [14:0] m_fv;
    logic        m_fvv;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Correct {C, S, ov} computed arithmetically with signed/unsigned integers
    function automatic logic [5:0] ref_res(input logic [3:0] a, input logic [3:0] b, input logic m);
        int ua, ub, sa, sb, r, sr;
        logic [3:0] es;
        logic ec, eo;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        r  = m ? ua - ub : ua + ub;
        es = r[3:0];
        ec = m ? (ua >= ub) : (r > 15);
        sr = m ? sa - sb : sa + sb;
        eo = (sr > 7) || (sr < -8);
        return {ec, es, eo};
    endfunction

    function automatic logic ref_fail(input logic [3:0] a, input logic [3:0] b, input logic m,
                                      input logic [3:0] s, input logic c, input logic ov);
        logic [5:0] r;
        r = ref_res(a, b, m);
        return (r[4:1] != s) || (r[5] != c) || (OV_EN && r[0] != ov);
    endfunction

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic m,
                         input logic [3:0] s, input logic c, input logic ov);
        bus.in_valid = v;
        bus.A = a;
        bus.B = b;
        bus.M = m;
        bus.Sum = s;
        bus.C_out = c;
        bus.ov = ov;
    endtask

    task automatic drive_tbl(input int i);
        drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].s, tbl[i].c, tbl[i].ov);
    endtask

    // One clock: advance the model with the stimulus held across the edge, then compare
    task automatic step(input logic f);
        logic acc, exp_mis;
        exp_t e, n;
        acc = bus.in_valid && (m_st == 2'b01);
        n.v = {bus.A, bus.B, bus.M, bus.Sum, bus.C_out, bus.ov};
        n.f = f;
        @(posedge clk);
        #1;
        exp_mis = 1'b0;
        if (rst) begin
            m_st = 2'b00; m_pass = 0; m_err = 0; m_fv = '0; m_fvv = 1'b0;
            q.delete();
        end else if (bus.start) begin
            m_st = 2'b01; m_pass = 0; m_err = 0; m_fv = '0; m_fvv = 1'b0;
            q.delete();
            if (acc) q.push_back(n);
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.f) begin
                    exp_mis = 1'b1;
                    if (m_err < 255) m_err++;
                    if (!m_fvv) begin m_fv = e.v; m_fvv = 1'b1; end
                    if (bus.halt_on_err && m_st == 2'b01) m_st = 2'b10;
                end else if (m_pass < 255) begin
                    m_pass++;
                end
            end
            if (acc) q.push_back(n);
        end
        chk("mismatch", 32'(bus.mismatch), 32'(exp_mis));
        chk("pass_count", 32'(bus.pass_count), 32'(m_pass));
        chk("err_count", 32'(bus.err_count), 32'(m_err));
        chk("state", 32'(bus.state), 32'(m_st));
        chk("in_ready", 32'(bus.in_ready), 32'(m_st == 2'b01));
        chk("fail_valid", 32'(bus.fail_valid), 32'(m_fvv));
        chk("fail_vec", 32'(bus.fail_vec), 32'(m_fv));
    endtask

    task automatic pulse_start(input logic halt);
        bus.halt_on_err = halt;
        bus.start = 1'b1;
        step(1'b0);
        bus.start = 1'b0;
    endtask

    initial begin
        logic [3:0] a, b;
        logic m;
        logic [5:0] r;
        tbl[0] = '{4'b0101, 4'b1010, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'b1001, 4'b0101, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4'b1010, 4'b1010, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{4'b0011, 4'b0100, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{4'b0010, 4'b0011, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b0};
        m_st = 2'b00; m_pass = 0; m_err = 0; m_fv = '0; m_fvv = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.halt_on_err = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        step(1'b0);

        // Back-to-back table vectors, no halting
        pulse_start(1'b0);
        for (int i = 0; i < 9; i++) begin
            drive_tbl(i);
            step(OV_EN ? tbl[i].fail_ov : tbl[i].fail_no);
        end
        bus.in_valid = 1'b0;
        step(1'b0);
        step(1'b0);

        // Halt on error; the vector accepted at the failing compare edge is still counted
        pulse_start(1'b1);
        drive_tbl(8);
        step(OV_EN ? tbl[8].fail_ov : tbl[8].fail_no);
        drive_tbl(0);
        step(1'b0);
        drive_tbl(1);
        step(1'b0);
        step(1'b0);
        bus.in_valid = 1'b0;
        step(1'b0);

        // Start coincident with a failing compare discards it
        pulse_start(1'b0);
        drive_tbl(0);
        step(1'b0);
        drive_tbl(5);
        step(1'b1);
        bus.in_valid = 1'b0;
        bus.start = 1'b1;
        step(1'b0);
        bus.start = 1'b0;
        step(1'b0);

        // 300 failing vectors saturate err_count; first one stays captured
        pulse_start(1'b0);
        for (int i = 0; i < 300; i++) begin
            a = 4'($urandom_range(15));
            b = 4'($urandom_range(15));
            m = 1'($urandom_range(1));
            r = ref_res(a, b, m);
            drive(1'b1, a, b, m, r[4:1] ^ 4'b0001, r[5], r[0]);
            step(ref_fail(a, b, m, r[4:1] ^ 4'b0001, r[5], r[0]));
        end
        drive_tbl(2);
        step(1'b0);
        bus.in_valid = 1'b0;
        step(1'b0);
        step(1'b0);

        // Reset while a failing vector is in the pipeline
        pulse_start(1'b0);
        drive_tbl(5);
        step(1'b1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
